aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Sequences the AES key-expansion core for 128/192/256-bit keys and captures its streamed round keys into a local buffer.
- Serves round keys to the cipher round datapath by index, with 1-cycle read latency.
- Sits between the key-load host interface and the cipher core. Owns the expansion core's start and key inputs.

Parameters:
- RK_MAX, 15: round-key buffer depth; covers the AES-256 maximum.
- KEY_W, 256: width of the key input bus. Shorter keys are left-aligned (MSBs).
- TIMEOUT, 64: stall limit in cycles; used only when KEY_SCHED_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  request to expand a new key; single-cycle pulse or level.
- key_in  input  256  cipher key, left-aligned.
- key_size  input  2  00=128, 01=192, 10=256, 11=reserved.
- busy  output  1  expansion in progress.
- keys_valid  output  1  buffer holds a complete, consistent key schedule.
- ke_start  output  1  start to the expansion core.
- ke_key  output  256  key to the core, registered at load acceptance.
- ke_size  output  2  key size to the core, registered at load acceptance.
- ke_subkey  input  128  round key streamed from the core.
- ke_rdy  input  1  ke_subkey valid this cycle; one round key per asserted cycle, in round order.
- rk_idx  input  4  round-key read index.
- rk_out  output  128  round key at rk_idx, registered.
- err  output  1  sticky error flag.

Behaviour:
- Reset (reset=0): all outputs 0, FSM returns to IDLE, wr_ptr=0, buffer contents don't-care. keys_valid=0 after reset.
- NRK (number of round keys) = 11 / 13 / 15 for key_size 00 / 01 / 10.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE, on load=1 with key_size!=11:
    - latch key_in→ke_key, key_size→ke_size, and NRK;
    - wr_ptr←0, keys_valid←0, busy←1, ke_start←1;
    - next state RUN.
  - load with key_size=11: ignored, err←1. State and keys_valid unchanged.
  - RUN: ke_start held high until the first ke_rdy cycle, then low.
  - RUN, each ke_rdy=1 cycle: buf[wr_ptr]←ke_subkey, wr_ptr←wr_ptr+1.
  - RUN, on ke_rdy=1 with wr_ptr=NRK-1: write the last key, busy←0, keys_valid←1, next state DONE.
    - keys_valid rises the cycle after the final ke_rdy.
  - ke_rdy=1 in IDLE or DONE: ignored; buffer untouched.
- load during RUN is ignored; the current expansion completes unchanged.
- load in DONE restarts the sequence: keys_valid drops the next cycle and the old schedule becomes unreadable.
- Read port: rk_out←buf[rk_idx] on each clock edge, 1-cycle latency.
  - rk_out←0 if keys_valid=0 or rk_idx>=NRK.
- Simultaneous final ke_rdy and a read of that index: rk_out returns 0 that cycle because keys_valid is still 0. Valid data follows from the next read.
- Reset asserted mid-RUN: immediate abort, keys_valid=0, ke_start=0.
- err is sticky; cleared only by reset.

Optional Feature:
- Macro: KEY_SCHED_TIMEOUT_EN.
- Defined:
  - stall counter increments each RUN cycle with ke_rdy=0 and clears on ke_rdy=1;
  - on reaching TIMEOUT: err←1, ke_start←0, busy←0, keys_valid stays 0, next state IDLE.
- Undefined: no counter. RUN waits indefinitely for ke_rdy.

Test Plan:
- 128-bit key 000102030405060708090a0b0c0d0e0f with the real core → keys_valid rises; rk_idx=0 gives 000102030405060708090a0b0c0d0e0f; rk_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5; rk_idx=11 gives 0.
- 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → exactly 13 captures; rk_idx=0 gives 8e73b0f7da0e6452c810f32b809079e5; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- Core model with ke_rdy gaps (pattern 1,0,0,1,…) → all 15 AES-256 keys captured in order; busy high throughout; keys_valid only after the 15th.
- load pulsed during RUN and key_size=11 in IDLE → first ignored, no restart; second sets err=1 with state unchanged. Reload in DONE → keys_valid low for the new run.
- reset driven low at the 5th ke_rdy, then released and a new key loaded → outputs 0 immediately; new schedule is correct with no stale keys.
- With KEY_SCHED_TIMEOUT_EN and the core never asserting ke_rdy → err=1 and busy=0 exactly TIMEOUT cycles after entering RUN; FSM back in IDLE.

Source files
------------

// File: rtl/aes_key_sched_ctrl_if.sv
// Link between the key-schedule controller (master) and the AES key-expansion core (slave).
interface aes_key_sched_ctrl_if #(
  parameter int KEY_W = 256
);
  logic             ke_start;
  logic [KEY_W-1:0] ke_key;
  logic [1:0]       ke_size;
  logic [127:0]     ke_subkey;
  logic             ke_rdy;

  modport master (
    output ke_start, ke_key, ke_size,
    input  ke_subkey, ke_rdy
  );

  modport slave (
    input  ke_start, ke_key, ke_size,
    output ke_subkey, ke_rdy
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: starts the expansion core, buffers its round keys and serves them by index.
// Optional stall watchdog enabled by defining KEY_SCHED_TIMEOUT_EN.
module aes_key_sched_ctrl #(
  parameter int RK_MAX  = 15,
  parameter int KEY_W   = 256,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [KEY_W-1:0]      key_in,
  input  logic [1:0]            key_size,
  output logic                  busy,
  output logic                  keys_valid,
  aes_key_sched_ctrl_if.master  ke,
  input  logic [3:0]            rk_idx,
  output logic [127:0]          rk_out,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [3:0]   wr_ptr;
  logic [3:0]   nrk;
  logic [127:0] rk_buf [RK_MAX];

  logic accept, reject, capture, last_key, timeout;

  function automatic logic [3:0] nrk_of(input logic [1:0] size);
    case (size)
      2'b00:   return 4'd11;
      2'b01:   return 4'd13;
      default: return 4'd15;
    endcase
  endfunction

  assign accept   = load && (key_size != 2'b11) && (state != RUN);
  assign reject   = load && (key_size == 2'b11) && (state != RUN);
  assign capture  = (state == RUN) && ke.ke_rdy;
  assign last_key = capture && (wr_ptr == nrk - 4'd1);

`ifdef KEY_SCHED_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;

  // Counter idles at zero outside RUN, so every run starts its stall budget afresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           stall_cnt <= '0;
    else if (state != RUN || ke.ke_rdy)   stall_cnt <= '0;
    else                                  stall_cnt <= stall_cnt + 1'b1;
  end

  assign timeout = (state == RUN) && !ke.ke_rdy && (stall_cnt == SW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // reader in this clock sees the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      nrk         <= '0;
      busy        <= 1'b0;
      keys_valid  <= 1'b0;
      ke.ke_start <= 1'b0;
      ke.ke_key   <= '0;
      ke.ke_size  <= '0;
      err         <= 1'b0;
    end else begin
      if (reject) err <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            ke.ke_key   <= key_in;
            ke.ke_size  <= key_size;
            nrk         <= nrk_of(key_size);
            wr_ptr      <= '0;
            keys_valid  <= 1'b0;
            busy        <= 1'b1;
            ke.ke_start <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (capture) begin
            ke.ke_start <= 1'b0;
            wr_ptr      <= wr_ptr + 4'd1;
            if (last_key) begin
              busy       <= 1'b0;
              keys_valid <= 1'b1;
              state      <= DONE;
            end
          end else if (timeout) begin
            err         <= 1'b1;
            ke.ke_start <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the key buffer has no reset; keys_valid gates every read, so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (capture) rk_buf[wr_ptr] <= ke.ke_subkey;
  end

  // keys_valid is the registered flag, so a read issued with the final ke_rdy still returns 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           rk_out <= '0;
    else if (keys_valid && rk_idx < nrk)  rk_out <= rk_buf[rk_idx];
    else                                  rk_out <= '0;
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: a table-driven core model streams round keys, read vectors check the buffer.
module tb_aes_key_sched_ctrl;

  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [255:0] key_in = '0;
  logic [1:0]   key_size = '0;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_idx = '0;
  logic [127:0] rk_out;
  logic         err;

  int checks = 0;
  int failures = 0;

  aes_key_sched_ctrl_if ke_if ();

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .key_in     (key_in),
    .key_size   (key_size),
    .busy       (busy),
    .keys_valid (keys_valid),
    .ke         (ke_if),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   size;
    logic [255:0] key;
    logic [127:0] last_rk;
    int           gap;
  } run_t;

  typedef struct {
    int           run;
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_vec_t;

  run_t    runs [5];
  rd_vec_t rd_vecs [$];

  function automatic int nrk_of(input logic [1:0] size);
    case (size)
      2'b00:   return 11;
      2'b01:   return 13;
      default: return 15;
    endcase
  endfunction

  // Round key i of run r as streamed by the core model; known endpoints, tagged filler in between.
  function automatic logic [127:0] core_rk(input int r, input int i);
    logic [255:0] k;
    int n;
    k = runs[r].key;
    n = nrk_of(runs[r].size);
    if (i == 0) return k[255:128];
    if (i == n - 1) return runs[r].last_rk;
    if (runs[r].size == 2'b10 && i == 1) return k[127:0];
    return {8'(r), 8'(i), 112'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int r);
    key_in   = runs[r].key;
    key_size = runs[r].size;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    key_in   = '0;
    key_size = 2'b00;
    check($sformatf("start%0d_ke_start", r), ke_if.ke_start, 1);
    check($sformatf("start%0d_busy", r), busy, 1);
    check($sformatf("start%0d_keys_valid", r), keys_valid, 0);
    check($sformatf("start%0d_ke_key", r), ke_if.ke_key, runs[r].key);
    check($sformatf("start%0d_ke_size", r), ke_if.ke_size, runs[r].size);
  endtask

  // Core model: streams the run's keys with runs[r].gap idle cycles between them.
  task automatic stream(input int r, input int abort_at, input int poke_at, input bit sim_read);
    int n;
    bit busy_ok;
    bit kv_ok;
    n = nrk_of(runs[r].size);
    busy_ok = 1'b1;
    kv_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      ke_if.ke_rdy    = 1'b1;
      ke_if.ke_subkey = core_rk(r, i);
      if (sim_read && i == n - 1) rk_idx = 4'(n - 1);
      if (i + 1 == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_keys_valid", keys_valid, 0);
        check("abort_ke_start", ke_if.ke_start, 0);
        check("abort_err", err, 0);
        check("abort_ke_key", ke_if.ke_key, 0);
        check("abort_rk_out", rk_out, 0);
        ke_if.ke_rdy = 1'b0;
        return;
      end
      tick();
      ke_if.ke_rdy = 1'b0;
      if (i == 0) check($sformatf("run%0d_ke_start_drop", r), ke_if.ke_start, 0);
      if (i < n - 1) begin
        if (!busy) busy_ok = 1'b0;
        if (keys_valid) kv_ok = 1'b0;
      end
      if (sim_read && i == n - 1) check("final_rdy_read_zero", rk_out, 0);
      if (i + 1 == poke_at) begin
        key_in   = ~runs[r].key;
        key_size = 2'b00;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        check("run_load_ke_key", ke_if.ke_key, runs[r].key);
        check("run_load_ke_size", ke_if.ke_size, runs[r].size);
        check("run_load_ke_start", ke_if.ke_start, 0);
        if (!busy) busy_ok = 1'b0;
      end
      if (i < n - 1) begin
        for (int g = 0; g < runs[r].gap; g++) begin
          tick();
          if (!busy) busy_ok = 1'b0;
          if (keys_valid) kv_ok = 1'b0;
        end
      end
    end
    check($sformatf("run%0d_busy_held", r), busy_ok, 1);
    check($sformatf("run%0d_kv_low_until_last", r), kv_ok, 1);
    check($sformatf("run%0d_keys_valid", r), keys_valid, 1);
    check($sformatf("run%0d_busy_done", r), busy, 0);
    check($sformatf("run%0d_ke_start_done", r), ke_if.ke_start, 0);
    if (sim_read) begin
      tick();
      check("final_read_next", rk_out, core_rk(r, n - 1));
    end
  endtask

  task automatic read_all(input int r);
    int n;
    n = nrk_of(runs[r].size);
    foreach (rd_vecs[v]) begin
      if (rd_vecs[v].run == r) begin
        rk_idx = rd_vecs[v].idx;
        tick();
        check($sformatf("vec_run%0d_idx%0d", r, rd_vecs[v].idx), rk_out, rd_vecs[v].exp);
      end
    end
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      tick();
      check($sformatf("sweep_run%0d_idx%0d", r, i), rk_out, (i < n) ? core_rk(r, i) : 128'h0);
    end
  endtask

  initial begin
    int cnt;

    runs[0] = '{2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h13111d7fe3944a17f307a78b4d2b30c5, 0};
    runs[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                128'he98ba06f448c773c8ecc720401002202, 0};
    runs[2] = '{2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h24fc79ccbf0979e9371ac23c6d68de36, 2};
    runs[3] = '{2'b10, 256'hf0e0d0c0b0a090807060504030201000ffeeddccbbaa99887766554433221100,
                128'hdeadbeef00112233445566778899aabb, 0};
    runs[4] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1};

    rd_vecs.push_back('{0, 4'd0,  128'h000102030405060708090a0b0c0d0e0f});
    rd_vecs.push_back('{0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5});
    rd_vecs.push_back('{0, 4'd11, 128'h0});
    rd_vecs.push_back('{1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5});
    rd_vecs.push_back('{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202});
    rd_vecs.push_back('{1, 4'd13, 128'h0});
    rd_vecs.push_back('{2, 4'd0,  128'h000102030405060708090a0b0c0d0e0f});
    rd_vecs.push_back('{2, 4'd1,  128'h101112131415161718191a1b1c1d1e1f});
    rd_vecs.push_back('{2, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36});
    rd_vecs.push_back('{2, 4'd15, 128'h0});
    rd_vecs.push_back('{4, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
    rd_vecs.push_back('{4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    rd_vecs.push_back('{4, 4'd12, 128'h0});

    ke_if.ke_rdy    = 1'b0;
    ke_if.ke_subkey = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_keys_valid", keys_valid, 0);
    check("rst_ke_start", ke_if.ke_start, 0);
    check("rst_ke_key", ke_if.ke_key, 0);
    check("rst_ke_size", ke_if.ke_size, 0);
    check("rst_rk_out", rk_out, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    tick();

    // Reserved key size in IDLE: flagged, otherwise ignored; stray ke_rdy in IDLE ignored
    key_size = 2'b11;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    key_size = 2'b00;
    check("rsv_idle_err", err, 1);
    check("rsv_idle_busy", busy, 0);
    check("rsv_idle_ke_start", ke_if.ke_start, 0);
    check("rsv_idle_keys_valid", keys_valid, 0);
    ke_if.ke_rdy    = 1'b1;
    ke_if.ke_subkey = '1;
    tick();
    ke_if.ke_rdy = 1'b0;
    check("idle_rdy_busy", busy, 0);

    // AES-128 with a read of the last index on the final ke_rdy
    start_run(0);
    stream(0, -1, -1, 1'b1);
    read_all(0);

    // AES-192 with load pulsed mid-run
    start_run(1);
    stream(1, -1, 3, 1'b0);
    read_all(1);

    // Reload in DONE: old schedule unreadable at once; AES-256 with ready gaps
    start_run(2);
    rk_idx = 4'd0;
    tick();
    check("reload_old_unreadable", rk_out, 0);
    stream(2, -1, -1, 1'b0);
    read_all(2);

    // Reserved size and stray ke_rdy in DONE leave the schedule intact
    key_size = 2'b11;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    key_size = 2'b00;
    check("rsv_done_keys_valid", keys_valid, 1);
    check("rsv_done_busy", busy, 0);
    ke_if.ke_rdy    = 1'b1;
    ke_if.ke_subkey = '1;
    tick();
    ke_if.ke_rdy = 1'b0;
    rk_idx = 4'd0;
    tick();
    check("done_rdy_idx0", rk_out, core_rk(2, 0));
    rk_idx = 4'd14;
    tick();
    check("done_rdy_idx14", rk_out, core_rk(2, 14));

    // Reset at the 5th ke_rdy, then a fresh AES-128 schedule with no stale keys
    start_run(3);
    stream(3, 5, -1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_abort_busy", busy, 0);
    start_run(4);
    stream(4, -1, -1, 1'b0);
    read_all(4);

`ifdef KEY_SCHED_TIMEOUT_EN
    start_run(0);
    cnt = 0;
    while (busy && cnt < 4 * TIMEOUT) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", 256'(cnt), 256'(TIMEOUT));
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_ke_start", ke_if.ke_start, 0);
    check("timeout_keys_valid", keys_valid, 0);
    start_run(4);
    stream(4, -1, -1, 1'b0);
`else
    start_run(0);
    cnt = 0;
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      tick();
      if (busy && !keys_valid && ke_if.ke_start) cnt++;
    end
    check("no_timeout_wait", 256'(cnt), 256'(2 * TIMEOUT));
    check("no_timeout_err", err, 0);
    stream(0, -1, -1, 1'b0);
    rk_idx = 4'd10;
    tick();
    check("no_timeout_idx10", rk_out, core_rk(0, 10));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
